// File: rtl/flex_fifo_pkg.sv
// Shared constants and helpers for flex_fifo: default sizing, level width and the
// per-edge operation encoding used by the occupancy counter.
package flex_fifo_pkg;

  localparam int DEF_ASIZE     = 4;
  localparam int DEF_DSIZE     = 32;
  localparam int DEF_AEMPTY_TH = 1;

  // Occupancy must represent 0..2**asize inclusive, hence one extra bit.
  function automatic int lvl_w(input int asize);
    return asize + 1;
  endfunction

  function automatic int def_afull_th(input int asize);
    return (2 ** asize) - 2;
  endfunction

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/flex_fifo_ptr.sv
// Wrap-around pointer: W-bit counter, sync reset/clear, increments on inc.
// The extra MSB beyond the address bits distinguishes full from empty.
module flex_fifo_ptr
  import flex_fifo_pkg::*;
#(
  parameter int W = DEF_ASIZE + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/flex_fifo.sv
// Single-clock first-word-fall-through FIFO, zero read latency; wr_ready/rd_valid depend only on state.
// Optional high-water mark tracking when FLEX_FIFO_WATERMARK_EN is defined.
module flex_fifo
  import flex_fifo_pkg::*;
#(
  parameter int ASIZE     = DEF_ASIZE,
  parameter int DSIZE     = DEF_DSIZE,
  parameter int AFULL_TH  = def_afull_th(ASIZE),
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_n,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [ASIZE:0]   level,
  output logic             almost_full,
  output logic             almost_empty
`ifdef FLEX_FIFO_WATERMARK_EN
  ,
  input  logic             wm_clear,
  output logic [ASIZE:0]   max_level
`endif
);

  localparam int LW    = lvl_w(ASIZE);
  localparam int DEPTH = 2 ** ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wr_ptr;
  logic [ASIZE:0]   rd_ptr;
  logic             full;
  logic             empty;
  logic             clr;
  logic             wr_fire;
  logic             rd_fire;
  fifo_op_e         op;

  flex_fifo_ptr #(.W(LW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .inc   (wr_fire),
    .ptr   (wr_ptr)
  );

  flex_fifo_ptr #(.W(LW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .inc   (rd_fire),
    .ptr   (rd_ptr)
  );

  assign clr   = ~clear_n;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                 (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);

  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;
  assign op       = fifo_op_e'({wr_fire, rd_fire});

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire && !clr && !rst) begin
      mem[wr_ptr[ASIZE-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr[ASIZE-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      level <= '0;
    end else begin
      case (op)
        OP_WR:   level <= level + LW'(1);
        OP_RD:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign almost_full  = (level >= LW'(AFULL_TH));
  assign almost_empty = (level <= LW'(AEMPTY_TH));

`ifdef FLEX_FIFO_WATERMARK_EN
  // Tracks registered level, so it trails level by one edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      max_level <= '0;
    end else if (wm_clear) begin
      max_level <= level;
    end else if (level > max_level) begin
      max_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_flex_fifo.sv
// Self-checking bench for flex_fifo (ASIZE=2, DSIZE=8) against a queue-based model.
module tb_flex_fifo;

  localparam int ASIZE = 2;
  localparam int DSIZE = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear_n = 1'b1;
  logic [DSIZE-1:0] wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [DSIZE-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [ASIZE:0]   level;
  logic             almost_full;
  logic             almost_empty;
`ifdef FLEX_FIFO_WATERMARK_EN
  logic             wm_clear = 1'b0;
  logic [ASIZE:0]   max_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DSIZE-1:0] q[$];
  int               mdl_max = 0;

  flex_fifo #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_n      (clear_n),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FLEX_FIFO_WATERMARK_EN
    ,
    .wm_clear     (wm_clear),
    .max_level    (max_level)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge, applying the FIFO rules to the model from the pre-edge occupancy.
  task automatic cyc();
    int  pre;
    bit  w;
    bit  r;
    @(posedge clk);
    pre = q.size();
    if (rst || !clear_n) begin
      q.delete();
      mdl_max = 0;
    end else begin
`ifdef FLEX_FIFO_WATERMARK_EN
      if (wm_clear) mdl_max = pre;
      else if (pre > mdl_max) mdl_max = pre;
`endif
      w = wr_valid && (pre < DEPTH);
      r = rd_ready && (pre > 0);
      if (r) void'(q.pop_front());
      if (w) q.push_back(wr_data);
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    clear_n  = 1'b1;
  endtask

  task automatic flush();
    idle_inputs();
    clear_n = 1'b0;
    cyc();
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr_valid = 1'b0;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", almost_full); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b want 1", almost_empty); end
  endtask

  task automatic test_fill_drain();
    logic [DSIZE-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = vals[i];
      cyc();
    end
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d want 4", level); end
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wr_ready got %b want 0", wr_ready); end
    n_tests++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_afull got %b want 1", almost_full); end
    wr_data = 8'h55;
    cyc();
    wr_valid = 1'b0;
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL overflow_level got %0d want 4", level); end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
        n_fail++; $display("FAIL drain_%0d got vld=%b data=%h want vld=1 data=%h", i, rd_valid, rd_data, vals[i]);
      end
      cyc();
    end
    rd_ready = 1'b0;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", rd_valid); end
  endtask

  task automatic test_full_rw();
    logic [DSIZE-1:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = vals[i];
      cyc();
    end
    wr_data = 8'h55; rd_ready = 1'b1;
    n_tests++; if (rd_data !== 8'h11 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_rw_pre got data=%h wr_ready=%b want data=11 wr_ready=0", rd_data, wr_ready);
    end
    cyc();
    rd_ready = 1'b0;
    n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL full_rw_level got %0d want 3", level); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_rw_retry_rdy got %b want 1", wr_ready); end
    cyc();
    wr_valid = 1'b0;
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_rw_retry_level got %0d want 4", level); end
    rd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_tests++; if (rd_data !== vals[i]) begin n_fail++; $display("FAIL full_rw_order_%0d got %h want %h", i, rd_data, vals[i]); end
      cyc();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_empty_no_forward();
    wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b1;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL nofwd_same_cycle got %b want 0", rd_valid); end
    cyc();
    wr_valid = 1'b0;
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      n_fail++; $display("FAIL nofwd_next got vld=%b data=%h want vld=1 data=a5", rd_valid, rd_data);
    end
    cyc();
    rd_ready = 1'b0;
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL nofwd_drained got %0d want 0", level); end
  endtask

  task automatic test_wrap();
    logic [DSIZE-1:0] prev;
    prev = 8'($urandom);
    wr_valid = 1'b1; wr_data = prev;
    cyc();
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'($urandom); rd_ready = 1'b1;
      n_tests++; if (rd_data !== prev) begin n_fail++; $display("FAIL wrap_data_%0d got %h want %h", i, rd_data, prev); end
      prev = wr_data;
      cyc();
      n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL wrap_level_%0d got %0d want 1", i, level); end
    end
    wr_valid = 1'b0;
    n_tests++; if (rd_data !== prev) begin n_fail++; $display("FAIL wrap_last got %h want %h", rd_data, prev); end
    cyc();
    rd_ready = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h60 + i);
      cyc();
    end
    n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL clear_pre_level got %0d want 3", level); end
    wr_data = 8'h77; clear_n = 1'b0; rd_ready = 1'b1;
    cyc();
    idle_inputs();
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL clear_level got %0d want 0", level); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_rd_valid got %b want 0", rd_valid); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL clear_aempty got %b want 1", almost_empty); end
  endtask

  task automatic test_random();
    int sz;
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      clear_n  = ($urandom_range(0, 40) != 0);
      sz = q.size();
      n_tests++; if (level !== 3'(sz) || rd_valid !== (sz > 0) || wr_ready !== (sz < DEPTH) ||
                     almost_full !== (sz >= 3) || almost_empty !== (sz <= 1)) begin
        n_fail++; $display("FAIL rand_flags_%0d got lvl=%0d vld=%b rdy=%b af=%b ae=%b want lvl=%0d", i,
                           level, rd_valid, wr_ready, almost_full, almost_empty, sz);
      end
      if (sz > 0) begin
        n_tests++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL rand_data_%0d got %h want %h", i, rd_data, q[0]); end
      end
      cyc();
    end
    idle_inputs();
  endtask

`ifdef FLEX_FIFO_WATERMARK_EN
  task automatic test_watermark();
    flush();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      cyc();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    rd_ready = 1'b0;
    n_tests++; if (max_level !== 3'd3 || mdl_max != 3) begin
      n_fail++; $display("FAIL wm_peak got %0d want 3 (model %0d)", max_level, mdl_max);
    end
    wm_clear = 1'b1;
    cyc();
    wm_clear = 1'b0;
    n_tests++; if (max_level !== 3'd0) begin n_fail++; $display("FAIL wm_clear got %0d want 0", max_level); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    test_reset();
    test_fill_drain();
    flush();
    test_full_rw();
    flush();
    test_empty_no_forward();
    test_wrap();
    flush();
    test_clear();
    test_random();
`ifdef FLEX_FIFO_WATERMARK_EN
    test_watermark();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
